modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Sequencer for 8-bit RSA modular exponentiation: computes result = base^exp mod modulus with left-to-right square-and-multiply. It time-shares a single external combinational 8x8 unsigned multiplier, the team's radix-4 partial-product multiplier. It reduces each 16-bit product with an internal bit-serial restoring remainder unit. It sits between the RSA key/message registers and the shared multiplier.

## Interface
Parameters: none; all widths fixed at 8-bit operands and 16-bit product.

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE
- base  in  8  message/base operand, unsigned
- exp  in  8  exponent, unsigned, MSB processed first
- modulus  in  8  modulus n, unsigned
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when result/err valid
- result  out  8  base^exp mod n; held until next accepted start
- err  out  1  set when n==0; held with result
- mul_a  out  8  multiplier operand A
- mul_b  out  8  multiplier operand B
- mul_p  in  16  product mul_a*mul_b, combinational, same cycle

## Operation
- States: IDLE, REDB, SQR, REDS, MUL, REDM.
- IDLE: if start, latch base, exp, modulus. Clear err. Set bit index i=7.
  - n==0: set err=1, result=0, pulse done on that same edge, stay IDLE.
  - Otherwise: r = (n==1) ? 0 : 1. Load reducer input with {8'h00, base}. Go to REDB.
- Reducer: 16-step restoring remainder, one step per cycle.
  - 9-bit partial remainder rem, cleared on load.
  - Step k = 15..0: rem = {rem[7:0], p[k]}; if rem >= n then rem = rem - n.
  - Invariant: rem < n before each shift, so rem < 2n <= 510 fits 9 bits.
  - Final rem[7:0] is the reduced value.
- REDB: 16 steps. Store reduced base in bred, then go to SQR.
- SQR: mul_a = mul_b = r. Capture mul_p into p, then go to REDS.
- REDS: 16 steps, then r = rem. If exp[i], go to MUL; else go to next-bit handling.
- MUL: mul_a = r, mul_b = bred. Capture mul_p, then go to REDM.
- REDM: 16 steps, then r = rem, then next-bit handling.
- Next-bit handling: if i==0, set result=r, pulse done, go to IDLE. Otherwise i = i-1, go to SQR.
- mul_a/mul_b are decoded combinationally from state and registers. They are 0 in every state other than SQR/MUL.
- start while busy is ignored. Latched operands are unaffected by input changes after acceptance.

## Timing
- Reset values: busy=0, done=0, result=0, err=0, mul_a=0, mul_b=0, state IDLE.
- Edge numbering: the edge that samples start is edge 0. With k = popcount(exp), done rises after edge 152+17k and is high for exactly one cycle.
  - Range: 152 edges (exp=0) to 288 edges (exp=255).
- busy rises after edge 0 and falls on the same edge that done rises.
- n==0 path: done and err rise after edge 0; busy stays 0.
- start asserted during the done cycle is accepted, since the state is already IDLE. The new operation begins with no idle cycle in between.
- reset has priority over everything, including an in-flight operation and a simultaneous start. Next cycle: IDLE, busy=0, done=0, result=0, err=0.
- mul_p must settle within the SQR/MUL cycle. The block does not register mul_a/mul_b.

## Test plan
- base=3, exp=5, n=7 -> result=5, err=0, done one cycle after edge 186, busy high edges 1..186.
- base=200, exp=0, n=13 -> result=1, done after edge 152. Then base=9, exp=3, n=1 -> result=0.
- base=255, exp=255, n=251 -> result=20, done after edge 288. mul_a/mul_b equal 0 outside SQR/MUL throughout.
- n=0, base=5, exp=9 -> err=1, result=0, done after edge 0, busy never high. Next start with n=7 clears err.
- Reset at edge 100 of a run; start pulses mid-run ignored -> IDLE and all outputs 0 next cycle. Rerun 3^5 mod 7 -> 5.
- Back-to-back: start held high across the done cycle of 3^5 mod 7 with new operands 2^10 mod 11 -> first result=5, second result=1 at 152+34 edges after re-acceptance.

Source files
------------

// File: rtl/modexp_ctrl.sv
// 8-bit modular exponentiation sequencer: left-to-right square-and-multiply over a
// shared external 8x8 multiplier, each product reduced by a bit-serial restoring remainder.
module modexp_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base,
  input  logic [7:0]  exp,
  input  logic [7:0]  modulus,
  output logic        busy,
  output logic        done,
  output logic [7:0]  result,
  output logic        err,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  typedef enum logic [2:0] {IDLE, REDB, SQR, REDS, MUL, REDM} state_t;

  state_t      r_state;
  logic [7:0]  r_exp;
  logic [7:0]  r_n;
  logic [7:0]  r_bred;
  logic [7:0]  r_r;
  logic [2:0]  r_i;
  logic [15:0] r_p;
  logic [8:0]  r_rem;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_result;
  logic        r_err;

  logic [8:0]  w_shift;
  logic [8:0]  w_rem_next;
  logic        w_last;

  // rem < n before each shift keeps the shifted value below 2n, so 9 bits suffice
  assign w_shift    = {r_rem[7:0], r_p[r_cnt]};
  assign w_rem_next = (w_shift >= {1'b0, r_n}) ? (w_shift - {1'b0, r_n}) : w_shift;
  assign w_last     = (r_cnt == 4'd0);

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (r_state)
      SQR: begin
        mul_a = r_r;
        mul_b = r_r;
      end
      MUL: begin
        mul_a = r_r;
        mul_b = r_bred;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_n      <= '0;
      r_bred   <= '0;
      r_r      <= '0;
      r_i      <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp <= exp;
            r_n   <= modulus;
            r_err <= 1'b0;
            r_i   <= 3'd7;
            if (modulus == 8'd0) begin
              r_err    <= 1'b1;
              r_result <= '0;
              r_done   <= 1'b1;
            end else begin
              r_r     <= (modulus == 8'd1) ? 8'd0 : 8'd1;
              r_p     <= {8'h00, base};
              r_rem   <= '0;
              r_cnt   <= 4'd15;
              r_busy  <= 1'b1;
              r_state <= REDB;
            end
          end
        end
        REDB: begin
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            r_bred  <= w_rem_next[7:0];
            r_state <= SQR;
          end
        end
        SQR, MUL: begin
          r_p     <= mul_p;
          r_rem   <= '0;
          r_cnt   <= 4'd15;
          r_state <= (r_state == SQR) ? REDS : REDM;
        end
        REDS, REDM: begin
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            r_r <= w_rem_next[7:0];
            if (r_state == REDS && r_exp[r_i]) begin
              r_state <= MUL;
            end else if (r_i == 3'd0) begin
              // result takes the freshly reduced value on the same edge r does
              r_result <= w_rem_next[7:0];
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_i     <= r_i - 3'd1;
              r_state <= SQR;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: directed vectors plus randomized operations
// checked against an arithmetic square-and-multiply reference and a latency formula.
module tb_modexp_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  base;
  logic [7:0]  exp;
  logic [7:0]  modulus;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        err;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;

  int n_checks = 0;
  int n_fail   = 0;

  modexp_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_p   (mul_p)
  );

  assign mul_p = {8'h00, mul_a} * {8'h00, mul_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ref_modexp(input logic [7:0] b, input logic [7:0] e,
                                            input logic [7:0] n);
    int unsigned r;
    if (n == 8'd0) return 8'd0;
    r = 1 % n;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r[7:0];
  endfunction

  function automatic int ref_latency(input logic [7:0] e, input logic [7:0] n);
    if (n == 8'd0) return 0;
    return 152 + 17 * $countones(e);
  endfunction

  // Starts one operation; returns edges from acceptance to done, the busy-violation
  // count, and the number of cycles with nonzero multiplier operands.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n,
                        input bit scramble, output int lat, output int busy_bad,
                        output int mul_nz);
    @(posedge clock); #1;
    base = b; exp = e; modulus = n; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; busy_bad = 0; mul_nz = 0;
    while (!done && lat < 400) begin
      if (busy !== 1'b1) busy_bad++;
      if (mul_a != 8'd0 || mul_b != 8'd0) mul_nz++;
      if (scramble) begin
        base = 8'($urandom); exp = 8'($urandom); modulus = 8'($urandom);
        start = (lat < 100) ? 1'($urandom) : 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_bad++;
  endtask

  task automatic check_op(input string tag, input logic [7:0] b, input logic [7:0] e,
                          input logic [7:0] n, input bit scramble);
    int lat, busy_bad, mul_nz;
    logic [7:0] exp_res;
    exp_res = ref_modexp(b, e, n);
    run_op(b, e, n, scramble, lat, busy_bad, mul_nz);
    n_checks++;
    if (lat != ref_latency(e, n)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, ref_latency(e, n));
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %0d expected %0d", tag, result, exp_res);
    end
    n_checks++;
    if (err !== (n == 8'd0)) begin
      n_fail++;
      $display("FAIL %s err: got %0b expected %0b", tag, err, (n == 8'd0));
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy: %0d bad cycles expected 0", tag, busy_bad);
    end
    n_checks++;
    if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
      n_fail++;
      $display("FAIL %s mul_idle: got a=%0d b=%0d expected 0", tag, mul_a, mul_b);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: got %0b expected 0", tag, done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({busy, done, result, err, mul_a, mul_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b done=%0b result=%0d err=%0b a=%0d b=%0d expected all 0",
               busy, done, result, err, mul_a, mul_b);
    end
  endtask

  task automatic test_vectors;
    int lat, busy_bad, mul_nz;
    check_op("v_3_5_7", 8'd3, 8'd5, 8'd7, 1'b0);
    check_op("v_200_0_13", 8'd200, 8'd0, 8'd13, 1'b0);
    check_op("v_9_3_1", 8'd9, 8'd3, 8'd1, 1'b0);
    check_op("v_255_255_251", 8'd255, 8'd255, 8'd251, 1'b0);
    // modulus is prime and base nonzero mod it, so every SQR/MUL cycle has nonzero operands
    run_op(8'd255, 8'd255, 8'd251, 1'b0, lat, busy_bad, mul_nz);
    n_checks++;
    if (mul_nz != 16) begin
      n_fail++;
      $display("FAIL mul_cycles: got %0d expected 16", mul_nz);
    end
    n_checks++;
    if (result !== 8'd20) begin
      n_fail++;
      $display("FAIL v_255_const: got %0d expected 20", result);
    end
  endtask

  task automatic test_err;
    check_op("err_n0", 8'd5, 8'd9, 8'd0, 1'b0);
    check_op("err_clear", 8'd3, 8'd5, 8'd7, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] b, e, n;
    for (int t = 0; t < 14; t++) begin
      b = 8'($urandom); e = 8'($urandom);
      n = (t == 0) ? 8'd0 : ((t == 1) ? 8'd1 : 8'($urandom));
      check_op($sformatf("rand%0d", t), b, e, n, 1'b1);
    end
  endtask

  task automatic test_reset_midrun;
    @(posedge clock); #1;
    base = 8'd3; exp = 8'd5; modulus = 8'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k < 100; k++) begin
      start = (k % 17 == 3);
      base = 8'd77; exp = 8'd1; modulus = 8'd0;
      @(posedge clock); #1;
    end
    reset = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    n_checks++;
    if ({busy, done, result, err, mul_a, mul_b} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%0b done=%0b result=%0d err=%0b a=%0d b=%0d expected all 0",
               busy, done, result, err, mul_a, mul_b);
    end
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy got %0b expected 0", busy);
    end
    check_op("rerun_3_5_7", 8'd3, 8'd5, 8'd7, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clock); #1;
    base = 8'd3; exp = 8'd5; modulus = 8'd7; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
    n_checks++;
    if (lat != 186 || result !== 8'd5) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d result=%0d expected lat=186 result=5", lat, result);
    end
    base = 8'd2; exp = 8'd10; modulus = 8'd11;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy got %0b expected 1", busy);
    end
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
    n_checks++;
    if (lat != ref_latency(8'd10, 8'd11) || result !== ref_modexp(8'd2, 8'd10, 8'd11)) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d result=%0d expected lat=%0d result=%0d", lat, result,
               ref_latency(8'd10, 8'd11), ref_modexp(8'd2, 8'd10, 8'd11));
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_err;
    test_reset_midrun;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
